// File: rtl/display_word_pager.sv
// Paged 4-digit hex view of a captured 32-bit word: high half then low half,
// advanced by a dwell timer or a debounced push-button.
module display_word_pager #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        auto_en,
  input  logic        btn_next,
  input  logic        blank_lz,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [3:0]  enables,
  output logic        page,
  output logic        valid
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SHOW_HI = 2'd1,
    SHOW_LO = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     word_q, word_d;
  logic [TW-1:0]   dwell_q, dwell_d;
  logic [1:0]      sync_q;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            deb_state_q, deb_state_d;
  logic            deb_prev_q;
  logic            next_pulse_s, showing_s, expire_s, advance_s;
  logic [15:0]     page_word_s;
  logic [15:0]     digits_q, digits_d;
  logic [3:0]      enables_q, enables_d;
  logic            page_q, page_d;
  logic            valid_q, valid_d;

  // Bit i (i>=1) is lit iff some nibble at position >= i is nonzero.
  function automatic logic [3:0] lz_enables(input logic [15:0] p);
    lz_enables = {|p[15:12], |p[15:8], |p[15:4], 1'b1};
  endfunction

  // Debounce: flip the qualified level after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    deb_cnt_d   = '0;
    deb_state_d = deb_state_q;
    if (sync_q[1] != deb_state_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_state_d = ~deb_state_q;
        deb_cnt_d   = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  assign next_pulse_s = deb_state_q & ~deb_prev_q;

  // Page FSM, word capture and dwell timer; load overrides any advance event.
  always_comb begin
    showing_s = (state_q != EMPTY);
    expire_s  = showing_s && auto_en && (dwell_q == TICK_LAST);
    advance_s = showing_s && (expire_s || next_pulse_s);
    state_d   = state_q;
    word_d    = word_q;
    dwell_d   = '0;
    if (load) begin
      state_d = SHOW_HI;
      word_d  = word_in;
      dwell_d = '0;
    end else begin
      case (state_q)
        EMPTY:   state_d = EMPTY;
        SHOW_HI: state_d = advance_s ? SHOW_LO : SHOW_HI;
        SHOW_LO: state_d = advance_s ? SHOW_HI : SHOW_LO;
        default: state_d = EMPTY;
      endcase
      if (showing_s && auto_en && !advance_s) begin
        dwell_d = dwell_q + TW'(1);
      end else begin
        dwell_d = '0;
      end
    end
  end

  // Display outputs derived from the current state and stored word.
  always_comb begin
    page_word_s = (state_q == SHOW_LO) ? word_q[15:0] : word_q[31:16];
    digits_d    = 16'h0000;
    enables_d   = 4'b0000;
    page_d      = 1'b0;
    valid_d     = 1'b0;
    case (state_q)
      SHOW_HI, SHOW_LO: begin
        digits_d  = page_word_s;
        enables_d = blank_lz ? lz_enables(page_word_s) : 4'b1111;
        page_d    = (state_q == SHOW_LO);
        valid_d   = 1'b1;
      end
      default: begin
        digits_d  = 16'h0000;
        enables_d = 4'b0000;
        page_d    = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // All state, including synchroniser and output registers, with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= EMPTY;
      word_q      <= 32'h0000_0000;
      dwell_q     <= '0;
      sync_q      <= 2'b00;
      deb_cnt_q   <= '0;
      deb_state_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      digits_q    <= 16'h0000;
      enables_q   <= 4'b0000;
      page_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      dwell_q     <= dwell_d;
      sync_q      <= {sync_q[0], btn_next};
      deb_cnt_q   <= deb_cnt_d;
      deb_state_q <= deb_state_d;
      deb_prev_q  <= deb_state_q;
      digits_q    <= digits_d;
      enables_q   <= enables_d;
      page_q      <= page_d;
      valid_q     <= valid_d;
    end
  end

  assign digit3  = digits_q[15:12];
  assign digit2  = digits_q[11:8];
  assign digit1  = digits_q[7:4];
  assign digit0  = digits_q[3:0];
  assign enables = enables_q;
  assign page    = page_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_display_word_pager.sv
// Bench for display_word_pager: scripted test-plan scenarios followed by random
// stimulus, all compared cycle by cycle against a behavioural model.
module tb_display_word_pager;

  localparam int TICK = 8;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        clear_n, load, auto_en, btn_next, blank_lz;
  logic [31:0] word_in;
  logic [3:0]  digit3, digit2, digit1, digit0, enables;
  logic        page, valid;

  int n_tests = 0;
  int n_fail  = 0;

  display_word_pager #(.TICK_DIV(TICK), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .clear_n(clear_n), .load(load), .word_in(word_in),
    .auto_en(auto_en), .btn_next(btn_next), .blank_lz(blank_lz),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .enables(enables), .page(page), .valid(valid)
  );

  always #5 clk = ~clk;

  // Model state: what is shown, the button as the design sees it, and the dwell age.
  logic [31:0] m_word;
  bit          m_show, m_page, m_s0, m_s1, m_deb, m_rose;
  int          m_dwell, m_run;
  logic [15:0] e_digits;
  logic [3:0]  e_en;
  logic        e_page, e_valid;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_enables(input logic [15:0] p, input logic blank);
    int top = 0;
    logic [3:0] en = 4'b0000;
    if (!blank) return 4'b1111;
    for (int i = 0; i < 4; i++)
      if (p[i*4 +: 4] != 4'h0) top = i;
    for (int i = 0; i <= top; i++) en[i] = 1'b1;
    return en;
  endfunction

  function automatic void model_reset();
    m_word = 32'h0; m_show = 0; m_page = 0; m_s0 = 0; m_s1 = 0;
    m_deb = 0; m_rose = 0; m_dwell = 0; m_run = 0;
  endfunction

  // Predict the outputs registered at the coming edge, then advance the model.
  function automatic void model_step();
    logic [15:0] pw;
    bit pulse, expire, adv;
    if (!clear_n) begin
      e_digits = 16'h0; e_en = 4'h0; e_page = 1'b0; e_valid = 1'b0;
      model_reset();
      return;
    end
    pw = m_page ? m_word[15:0] : m_word[31:16];
    if (m_show) begin
      e_digits = pw; e_en = exp_enables(pw, blank_lz); e_page = m_page; e_valid = 1'b1;
    end else begin
      e_digits = 16'h0; e_en = 4'h0; e_page = 1'b0; e_valid = 1'b0;
    end
    pulse  = m_rose;
    m_rose = 0;
    if (m_s1 != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb  = ~m_deb;
        m_run  = 0;
        m_rose = m_deb;
      end
    end else begin
      m_run = 0;
    end
    m_s1 = m_s0;
    m_s0 = btn_next;
    expire = m_show && auto_en && (m_dwell == TICK - 1);
    adv    = m_show && (pulse || expire);
    if (load) begin
      m_show = 1; m_page = 0; m_word = word_in; m_dwell = 0;
    end else if (m_show) begin
      if (adv) begin
        m_page  = ~m_page;
        m_dwell = 0;
      end else if (auto_en) begin
        m_dwell++;
      end else begin
        m_dwell = 0;
      end
    end
  endfunction

  task automatic step(input logic c, input logic ld, input logic [31:0] w,
                      input logic a, input logic b, input logic bl);
    clear_n = c; load = ld; word_in = w; auto_en = a; btn_next = b; blank_lz = bl;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("digits", {16'h0, digit3, digit2, digit1, digit0}, {16'h0, e_digits});
    check_val("enables", {28'h0, enables}, {28'h0, e_en});
    check_val("page", {31'h0, page}, {31'h0, e_page});
    check_val("valid", {31'h0, valid}, {31'h0, e_valid});
  endtask

  initial begin
    logic btn_lvl;
    int   btn_left;
    model_reset();
    // Reset then load, then auto paging.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h1234_ABCD, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Debounce: glitch, held press, release, second press.
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    // Blanking on 0x000000A0 across both pages.
    step(1'b1, 1'b1, 32'h0000_00A0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    // Load racing expiry and a button pulse, then dwell racing a pulse.
    step(1'b1, 1'b1, 32'h1111_2222, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 1'b1, i > 8, 1'b0);
    // Reset mid-debounce in SHOW_LO, then a held button must requalify.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    // Random phase: held button runs, occasional loads, resets and mode changes.
    btn_lvl  = 1'b0;
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        btn_lvl  = ~btn_lvl;
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 24) == 0), $urandom(),
           ($urandom_range(0, 9) != 0), btn_lvl, ($urandom_range(0, 1) == 1));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
